// File: rtl/uart_byte_tx_pkg.sv
// Shared definitions for the UART byte path: 2-bit state encoding and default bit timing.
// The receiver and message modules import this package too.
package uart_byte_tx_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA      = 2'd2,
    STOP_BIT  = 2'd3
  } state_e;

  localparam int unsigned CLK_PER_BIT_DEF = 50;

endpackage

// File: rtl/uart_byte_tx_if.sv
// Byte-request / serial-line bundle between a byte producer (master) and the transmitter (slave).
interface uart_byte_tx_if;
  logic [7:0] data;
  logic       new_data;
  logic       block;
  logic       busy;
  logic       tx;

  modport master (output data, output new_data, output block, input busy, input tx);
  modport slave  (input data, input new_data, input block, output busy, output tx);
endinterface

// File: rtl/uart_byte_tx.sv
// 8N1 UART transmitter: accepts one byte in IDLE and shifts it out LSB first,
// CLK_PER_BIT clocks per bit, with a registered tx line.
module uart_byte_tx
  import uart_byte_tx_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = CLK_PER_BIT_DEF
) (
  input  logic           clk,
  input  logic           rst,
  uart_byte_tx_if.slave  bus
);

  localparam int unsigned CTR_SIZE = $clog2(CLK_PER_BIT);
  localparam logic [CTR_SIZE-1:0] CTR_MAX = CTR_SIZE'(CLK_PER_BIT - 1);

  state_e              state_q, state_d;
  logic [CTR_SIZE-1:0] ctr_q, ctr_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          data_q, data_d;
  logic                tx_q, tx_d;
  logic                bit_end;

  assign bit_end = (ctr_q == CTR_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ctr_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
    end
  end

  // tx_d is the value the line takes in the next cycle, so each branch
  // presents the level of the state being entered.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    bit_d   = bit_q;
    data_d  = data_q;
    tx_d    = tx_q;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (bus.new_data && !bus.block) begin
          data_d  = bus.data;
          ctr_d   = '0;
          bit_d   = '0;
          state_d = START_BIT;
          tx_d    = 1'b0;
        end
      end
      START_BIT: begin
        tx_d = 1'b0;
        if (bit_end) begin
          ctr_d   = '0;
          bit_d   = '0;
          state_d = DATA;
          tx_d    = data_q[0];
        end else begin
          ctr_d = ctr_q + CTR_SIZE'(1);
        end
      end
      DATA: begin
        tx_d = data_q[bit_q];
        if (bit_end) begin
          ctr_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP_BIT;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = data_q[bit_q + 3'd1];
          end
        end else begin
          ctr_d = ctr_q + CTR_SIZE'(1);
        end
      end
      STOP_BIT: begin
        tx_d = 1'b1;
        if (bit_end) begin
          ctr_d   = '0;
          state_d = IDLE;
        end else begin
          ctr_d = ctr_q + CTR_SIZE'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_comb begin
    bus.busy = (state_q != IDLE) || bus.block;
    bus.tx   = tx_q;
  end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Bench for uart_byte_tx at CLK_PER_BIT=4: table of byte requests plus hand sequences,
// with a serial-line monitor checking each decoded frame against a queue of expected bytes.
module tb_uart_byte_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_byte_tx_if bus();

  uart_byte_tx #(.CLK_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int frames = 0;
  logic [7:0] exp_q[$];
  int         starts[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Serial monitor: captures FRAME samples from the first low tx cycle, then the idle cycle after.
  bit               mon_act  = 1'b0;
  bit               mon_tail = 1'b0;
  int               mon_n    = 0;
  logic [FRAME-1:0] mon_tx, mon_bsy, ev;
  logic [7:0]       eb;

  always @(negedge clk) begin
    if (rst) begin
      mon_act  = 1'b0;
      mon_tail = 1'b0;
    end else if (mon_tail) begin
      mon_tail = 1'b0;
      check("frame_end_tx", 64'(bus.tx), 64'd1);
      check("frame_end_busy", 64'(bus.busy), 64'(bus.block));
    end else if (!mon_act) begin
      if (bus.tx === 1'b0) begin
        mon_act    = 1'b1;
        mon_tx     = '1;
        mon_bsy    = '0;
        mon_tx[0]  = bus.tx;
        mon_bsy[0] = bus.busy;
        mon_n      = 1;
        starts.push_back(cyc);
      end
    end else begin
      mon_tx[mon_n]  = bus.tx;
      mon_bsy[mon_n] = bus.busy;
      mon_n++;
      if (mon_n == FRAME) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got frame %0h, required no frame", mon_tx);
        end else begin
          eb = exp_q.pop_front();
          for (int k = 0; k < FRAME; k++) begin
            if (k < CPB)           ev[k] = 1'b0;
            else if (k < 9 * CPB)  ev[k] = eb[(k - CPB) / CPB];
            else                   ev[k] = 1'b1;
          end
          check("frame_tx", 64'(mon_tx), 64'(ev));
          check("frame_busy", 64'(mon_bsy), 64'({FRAME{1'b1}}));
        end
        frames++;
        mon_act  = 1'b0;
        mon_tail = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: busy still high after 200 cycles, required low", name);
    end
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       blk;
    logic       acc;
  } vec_t;

  vec_t vt[8];
  int   f0, s0;
  bit   seen;

  initial begin
    vt[0] = '{8'h55, 1'b0, 1'b1};
    vt[1] = '{8'h00, 1'b0, 1'b1};
    vt[2] = '{8'hFF, 1'b0, 1'b1};
    vt[3] = '{8'h80, 1'b0, 1'b1};
    vt[4] = '{8'h01, 1'b0, 1'b1};
    vt[5] = '{8'h12, 1'b1, 1'b0};
    vt[6] = '{8'h12, 1'b0, 1'b1};
    vt[7] = '{8'hC6, 1'b0, 1'b1};

    bus.data     = 8'h00;
    bus.new_data = 1'b0;
    bus.block    = 1'b0;

    // Reset state, busy follows block while in reset
    #12;
    check("rst_tx", 64'(bus.tx), 64'd1);
    check("rst_busy_blk0", 64'(bus.busy), 64'd0);
    bus.block = 1'b1;
    #1;
    check("rst_busy_blk1", 64'(bus.busy), 64'd1);
    bus.block = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Table-driven requests; data is scrambled right after acceptance
    foreach (vt[i]) begin
      tick();
      f0           = frames;
      bus.block    = vt[i].blk;
      bus.data     = vt[i].d;
      bus.new_data = 1'b1;
      if (vt[i].acc) exp_q.push_back(vt[i].d);
      tick();
      bus.new_data = 1'b0;
      bus.data     = ~vt[i].d;
      @(negedge clk);
      check("vec_tx", 64'(bus.tx), vt[i].acc ? 64'd0 : 64'd1);
      check("vec_busy", 64'(bus.busy), 64'd1);
      if (!vt[i].acc) begin
        repeat (8) @(negedge clk);
        check("blocked_tx", 64'(bus.tx), 64'd1);
        check("blocked_no_frame", 64'(frames), 64'(f0));
        tick();
        bus.block = 1'b0;
      end
      wait_idle("vec_idle");
      check("vec_q_empty", 64'(exp_q.size()), 64'd0);
    end

    // 0xA3 with a 0xFF request 20 cycles into the frame, which must be dropped
    tick();
    f0           = frames;
    bus.data     = 8'hA3;
    bus.new_data = 1'b1;
    exp_q.push_back(8'hA3);
    tick();
    bus.new_data = 1'b0;
    repeat (19) tick();
    bus.data     = 8'hFF;
    bus.new_data = 1'b1;
    tick();
    bus.new_data = 1'b0;
    wait_idle("ignore_idle");
    repeat (20) @(negedge clk);
    check("ignore_frames", 64'(frames - f0), 64'd1);
    check("ignore_q_empty", 64'(exp_q.size()), 64'd0);

    // new_data held high: acceptances every FRAME+1 cycles
    tick();
    s0 = starts.size();
    bus.data = 8'h00;
    repeat (3) exp_q.push_back(8'h00);
    bus.new_data = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (starts.size() >= s0 + 3) seen = 1'b1;
    end
    tick();
    bus.new_data = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL b2b_starts: got %0d frame starts, required 3", starts.size() - s0);
    end else begin
      check("b2b_gap1", 64'(starts[s0+1] - starts[s0]), 64'(FRAME + 1));
      check("b2b_gap2", 64'(starts[s0+2] - starts[s0+1]), 64'(FRAME + 1));
    end
    wait_idle("b2b_idle");
    check("b2b_q_empty", 64'(exp_q.size()), 64'd0);

    // Reset 15 cycles into a frame, then 0x0F right after release
    tick();
    bus.data     = 8'h3C;
    bus.new_data = 1'b1;
    exp_q.push_back(8'h3C);
    tick();
    bus.new_data = 1'b0;
    repeat (15) tick();
    rst = 1'b1;
    #1;
    check("midrst_tx", 64'(bus.tx), 64'd1);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    exp_q.delete();
    tick();
    rst          = 1'b0;
    bus.data     = 8'h0F;
    bus.new_data = 1'b1;
    exp_q.push_back(8'h0F);
    tick();
    bus.new_data = 1'b0;
    @(negedge clk);
    check("postrst_tx", 64'(bus.tx), 64'd0);
    check("postrst_busy", 64'(bus.busy), 64'd1);
    wait_idle("postrst_idle");
    check("postrst_q_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
